// File: rtl/bpu_gshare.sv
// IF-stage branch predictor: tagged BTB, gshare PHT of 2-bit counters and a circular
// return address stack, with EX-stage misprediction detection, training and history repair.

module bpu_gshare #(
  parameter int IDX_W     = 10,
  parameter int TAG_W     = 8,
  parameter int GHR_W     = 8,
  parameter int RAS_DEPTH = 8,
  parameter bit GSHARE_EN = 1'b1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic [31:0] if_pc,
  input  logic        suspend,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_error,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic        ex_is_call,
  input  logic        ex_is_ret,
  input  logic        real_taken,
  input  logic [31:0] real_target
);

  localparam int N     = 1 << IDX_W;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

  localparam logic [1:0] T_COND = 2'd0;
  localparam logic [1:0] T_JUMP = 2'd1;
  localparam logic [1:0] T_CALL = 2'd2;
  localparam logic [1:0] T_RET  = 2'd3;

  function automatic logic [GHR_W-1:0] ghr_shift(input logic [GHR_W-1:0] h, input logic b);
    logic [GHR_W:0] t;
    t = {h, b};
    return t[GHR_W-1:0];
  endfunction

  function automatic logic [1:0] ctr_sat(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  // Prediction tables and speculative history
  logic [N-1:0]           btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q  [N];
  logic [31:0]            btb_tgt_q  [N];
  logic [1:0]             btb_type_q [N];
  logic [N-1:0][1:0]      pht_q;
  logic [GHR_W-1:0]       ghr_q, ghr_d;
  logic [RAS_DEPTH-1:0][31:0] ras_q;
  logic [PTR_W-1:0]       ras_ptr_q;
  logic [PTR_W:0]         ras_cnt_q;

  // IF -> ID -> EX prediction state
  logic [IDX_W-1:0] id_btb_idx_q, ex_btb_idx_q;
  logic [IDX_W-1:0] id_pht_idx_q, ex_pht_idx_q;
  logic             id_taken_q,   ex_taken_q;
  logic [31:0]      id_target_q,  ex_target_q;
  logic [GHR_W-1:0] id_ghr_q,     ex_ghr_q;

  // ---------------- IF: combinational lookup ----------------
  logic [IDX_W-1:0] if_idx, if_pht_idx, ghr_ext;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [1:0]       if_type;
  logic [PTR_W-1:0] ras_top_idx;
  logic [31:0]      pc_plus4;

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
  end

  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[31:32-TAG_W];
  assign if_hit      = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
  assign if_type     = btb_type_q[if_idx];
  assign if_pht_idx  = GSHARE_EN ? (if_idx ^ ghr_ext) : if_idx;
  assign ras_top_idx = ras_ptr_q - PTR_W'(1);
  assign pc_plus4    = if_pc + 32'd4;

  assign pred_taken = cpu_rstn & if_hit & ((if_type != T_COND) | pht_q[if_pht_idx][1]);

  always_comb begin
    pred_target = pc_plus4;
    if (pred_taken) begin
      if (if_type == T_RET && ras_cnt_q != '0) pred_target = ras_q[ras_top_idx];
      else                                     pred_target = btb_tgt_q[if_idx];
    end
  end

  // ---------------- EX: resolution ----------------
  logic             ex_bj, ex_hit, dir_err, tgt_err;
  logic [1:0]       ex_type;
  logic [TAG_W-1:0] ex_tag;

  assign ex_bj   = ex_branch | ex_jump;
  assign ex_tag  = ex_pc[31:32-TAG_W];
  assign ex_hit  = btb_valid_q[ex_btb_idx_q] && (btb_tag_q[ex_btb_idx_q] == ex_tag);
  assign ex_type = ex_is_ret ? T_RET : ex_is_call ? T_CALL : ex_jump ? T_JUMP : T_COND;

  assign dir_err = ex_bj ? (ex_taken_q != real_taken) : ex_taken_q;
  assign tgt_err = ex_bj & ex_taken_q & real_taken & (ex_target_q != real_target);
  assign pred_error = cpu_rstn & ex_valid & (dir_err | tgt_err);

  // Repair from the EX snapshot wins over the speculative IF shift.
  always_comb begin
    ghr_d = ghr_q;
    if (pred_error)
      ghr_d = ex_branch ? ghr_shift(ex_ghr_q, real_taken) : ex_ghr_q;
    else if (!suspend && if_hit && if_type == T_COND)
      ghr_d = ghr_shift(ghr_q, pred_taken);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) ghr_q <= '0;
    else           ghr_q <= ghr_d;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      id_btb_idx_q <= '0;
      id_pht_idx_q <= '0;
      id_taken_q   <= 1'b0;
      id_target_q  <= '0;
      id_ghr_q     <= '0;
      ex_btb_idx_q <= '0;
      ex_pht_idx_q <= '0;
      ex_taken_q   <= 1'b0;
      ex_target_q  <= '0;
      ex_ghr_q     <= '0;
    end else begin
      if (!suspend) begin
        id_btb_idx_q <= if_idx;
        id_pht_idx_q <= if_pht_idx;
        id_taken_q   <= pred_taken;
        id_target_q  <= pred_target;
        id_ghr_q     <= ghr_q;
        ex_btb_idx_q <= id_btb_idx_q;
        ex_pht_idx_q <= id_pht_idx_q;
        ex_taken_q   <= id_taken_q;
        ex_target_q  <= id_target_q;
        ex_ghr_q     <= id_ghr_q;
      end
      // Wrong-path instructions behind a misprediction lose their prediction.
      if (pred_error) begin
        id_taken_q <= 1'b0;
        ex_taken_q <= 1'b0;
      end
    end
  end

  // ---------------- Training ----------------
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) pht_q <= {N{2'b01}};
    else if (ex_valid && ex_branch)
      pht_q[ex_pht_idx_q] <= ctr_sat(pht_q[ex_pht_idx_q], real_taken);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) btb_valid_q <= '0;
    else if (ex_valid) begin
      if (ex_bj && real_taken && !ex_hit)        btb_valid_q[ex_btb_idx_q] <= 1'b1;
      else if (!ex_bj && ex_taken_q && ex_hit)   btb_valid_q[ex_btb_idx_q] <= 1'b0;
    end
  end

  // Entry payload is meaningless while invalid, so it carries no reset.
  always_ff @(posedge cpu_clk) begin
    if (ex_valid && ex_bj) begin
      if (ex_hit) begin
        btb_type_q[ex_btb_idx_q] <= ex_type;
        if (real_taken) btb_tgt_q[ex_btb_idx_q] <= real_target;
      end else if (real_taken) begin
        btb_tag_q[ex_btb_idx_q]  <= ex_tag;
        btb_tgt_q[ex_btb_idx_q]  <= real_target;
        btb_type_q[ex_btb_idx_q] <= ex_type;
      end
    end
  end

  // Circular RAS: a push on a full stack silently overwrites the oldest entry.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ras_q     <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else if (ex_valid) begin
      if (ex_is_call) begin
        ras_q[ras_ptr_q] <= ex_pc + 32'd4;
        ras_ptr_q        <= ras_ptr_q + PTR_W'(1);
        if (ras_cnt_q != RAS_FULL) ras_cnt_q <= ras_cnt_q + (PTR_W+1)'(1);
      end else if (ex_is_ret && ras_cnt_q != '0) begin
        ras_ptr_q <= ras_ptr_q - PTR_W'(1);
        ras_cnt_q <= ras_cnt_q - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_bpu_gshare.sv
// Randomized bench for bpu_gshare: a small static program is streamed through a
// three-stage fetch/decode/execute model kept against abstract predictor tables.

module tb_bpu_gshare;

  localparam int IDX_W     = 10;
  localparam int TAG_W     = 8;
  localparam int GHR_W     = 8;
  localparam int RAS_DEPTH = 8;
  localparam int N         = 1 << IDX_W;
  localparam int unsigned GMASK = (1 << GHR_W) - 1;
  localparam int NI        = 13;

  localparam int C_COND = 0, C_JUMP = 1, C_CALL = 2, C_RET = 3, C_NONE = 4, C_CALLRET = 5;

  logic        cpu_clk, cpu_rstn, suspend;
  logic [31:0] if_pc, pred_target, ex_pc, real_target;
  logic        pred_taken, pred_error;
  logic        ex_valid, ex_branch, ex_jump, ex_is_call, ex_is_ret, real_taken;

  bpu_gshare #(
    .IDX_W(IDX_W), .TAG_W(TAG_W), .GHR_W(GHR_W), .RAS_DEPTH(RAS_DEPTH), .GSHARE_EN(1'b1)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .if_pc(if_pc), .suspend(suspend),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_error(pred_error),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_is_call(ex_is_call), .ex_is_ret(ex_is_ret), .real_taken(real_taken),
    .real_target(real_target)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Static program: 0x1C001010 aliases 0x1C000010 (same index and tag), 0x2C000010 shares only the index.
  int unsigned st_pc  [NI] = '{32'h1C000000, 32'h1C000010, 32'h1C001010, 32'h1C000020,
                               32'h1C000030, 32'h1C000034, 32'h1C000040, 32'h1C000044,
                               32'h1C000050, 32'h1C000060, 32'h1C000070, 32'h2C000010,
                               32'h1C001000};
  int          st_cls [NI] = '{C_COND, C_COND, C_NONE, C_JUMP, C_CALL, C_CALL, C_RET, C_RET,
                               C_COND, C_COND, C_CALLRET, C_COND, C_NONE};
  int unsigned st_tgt [NI] = '{32'h1C000100, 32'h1C000200, 32'h0, 32'h1C000400,
                               32'h1C000800, 32'h1C000900, 32'h1C000044, 32'h1C000048,
                               32'h1C000300, 32'h1C000500, 32'h1C000A00, 32'h1C000600,
                               32'h0};
  int          st_bias[NI] = '{100, 70, 0, 0, 0, 0, 0, 0, 30, 50, 0, 60, 0};

  // Abstract predictor state; the RAS is a plain stack capped at RAS_DEPTH entries.
  bit          m_valid[N];
  int unsigned m_tag  [N];
  int unsigned m_tgt  [N];
  int          m_type [N];
  int          m_pht  [N];
  int unsigned m_ghr;
  int unsigned m_ras[$];

  typedef struct {
    bit          v;
    bit          fl;
    int          si;
    bit          pt;
    int unsigned ptgt;
    int unsigned snap;
    int unsigned pidx;
  } slot_t;

  slot_t s_id, s_ex;

  function automatic void model_reset();
    foreach (m_valid[i]) begin
      m_valid[i] = 1'b0;
      m_pht[i]   = 1;
    end
    m_ghr = 0;
    m_ras.delete();
    s_id = '{v: 1'b0, fl: 1'b0, si: 0, pt: 1'b0, ptgt: 0, snap: 0, pidx: 0};
    s_ex = s_id;
  endfunction

  task automatic step(input int si, input bit susp);
    int unsigned pc, idx, pidx, ptgt, rtgt, epc, eidx, etag, ghr_n;
    bit hit, pt, act, br, jp, ca, re, rt, bj, perr, ehit;
    int typ, ecls, etype;
    slot_t nw;
    @(negedge cpu_clk);
    pc = st_pc[si];
    if_pc = pc;
    suspend = susp;
    act  = !susp && s_ex.v && !s_ex.fl;
    ecls = st_cls[s_ex.si];
    epc  = st_pc[s_ex.si];
    br = (ecls == C_COND);
    jp = (ecls inside {C_JUMP, C_CALL, C_RET, C_CALLRET});
    ca = (ecls inside {C_CALL, C_CALLRET});
    re = (ecls inside {C_RET, C_CALLRET});
    rtgt = st_tgt[s_ex.si];
    if (br)                          rt = ($urandom_range(0, 99) < st_bias[s_ex.si]);
    else                             rt = jp;
    if (ecls == C_RET && m_ras.size() > 0 && $urandom_range(0, 3) != 0) rtgt = m_ras[$];
    if (ecls == C_NONE)              rtgt = $urandom;
    ex_valid = act; ex_pc = epc; ex_branch = br; ex_jump = jp;
    ex_is_call = ca; ex_is_ret = re; real_taken = rt; real_target = rtgt;
    #1;
    // Expected IF prediction from the current tables
    idx  = (pc >> 2) % N;
    pidx = idx ^ m_ghr;
    hit  = m_valid[idx] && (m_tag[idx] == (pc >> (32 - TAG_W)));
    typ  = m_type[idx];
    pt   = hit && (typ != 0 || m_pht[pidx] >= 2);
    if (!pt)                             ptgt = pc + 4;
    else if (typ == 3 && m_ras.size() > 0) ptgt = m_ras[$];
    else                                 ptgt = m_tgt[idx];
    check_eq("pred_taken", pred_taken, pt);
    check_eq("pred_target", pred_target, ptgt);
    bj = br || jp;
    perr = 1'b0;
    if (act) perr = (bj ? (s_ex.pt != rt) : s_ex.pt) || (bj && s_ex.pt && rt && s_ex.ptgt != rtgt);
    check_eq("pred_error", pred_error, perr);
    ghr_n = m_ghr;
    if (perr)                            ghr_n = br ? (((s_ex.snap << 1) | rt) & GMASK) : s_ex.snap;
    else if (!susp && hit && typ == 0)   ghr_n = ((m_ghr << 1) | pt) & GMASK;
    if (act) begin
      eidx  = (epc >> 2) % N;
      etag  = epc >> (32 - TAG_W);
      ehit  = m_valid[eidx] && (m_tag[eidx] == etag);
      etype = re ? 3 : ca ? 2 : jp ? 1 : 0;
      if (br) m_pht[s_ex.pidx] = rt ? ((m_pht[s_ex.pidx] < 3) ? m_pht[s_ex.pidx] + 1 : 3)
                                    : ((m_pht[s_ex.pidx] > 0) ? m_pht[s_ex.pidx] - 1 : 0);
      if (bj && ehit) begin
        m_type[eidx] = etype;
        if (rt) m_tgt[eidx] = rtgt;
      end else if (bj && rt) begin
        m_valid[eidx] = 1'b1; m_tag[eidx] = etag; m_tgt[eidx] = rtgt; m_type[eidx] = etype;
      end else if (!bj && s_ex.pt && ehit) begin
        m_valid[eidx] = 1'b0;
      end
      if (ca) begin
        m_ras.push_back(epc + 4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (re && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (!susp) begin
      nw = '{v: 1'b1, fl: 1'b0, si: si, pt: pt, ptgt: ptgt, snap: m_ghr, pidx: pidx};
      s_ex = s_id;
      s_id = nw;
    end
    if (perr) begin
      s_id.fl = 1'b1; s_id.pt = 1'b0;
      s_ex.fl = 1'b1; s_ex.pt = 1'b0;
    end
    m_ghr = ghr_n;
  endtask

  // Reset asserted between edges must clear outputs at once and discard all state.
  task automatic apply_reset(input bit mid_run);
    if (mid_run) begin
      @(negedge cpu_clk);
      #2;
    end
    cpu_rstn = 1'b0;
    suspend = 1'b1;
    if_pc = 32'h1C000000;
    ex_pc = 32'h1C000000;
    ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0;
    ex_is_call = 1'b0; ex_is_ret = 1'b0;
    real_taken = 1'b1; real_target = 32'h1C000100;
    #1;
    check_eq("rst_pred_taken", pred_taken, 32'h0);
    check_eq("rst_pred_target", pred_target, 32'h1C000004);
    check_eq("rst_pred_error", pred_error, 32'h0);
    ex_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int k = 0; k < n; k++) step($urandom_range(0, NI - 1), $urandom_range(0, 9) == 0);
  endtask

  initial begin
    apply_reset(1'b0);
    // Cold start on a single always-taken branch
    repeat (12) step(0, 1'b0);
    // History with interleaved suspend cycles
    for (int k = 0; k < 24; k++) step((k % 3 == 0) ? 8 : (k % 3 == 1) ? 1 : 9, (k % 5) == 2);
    // Deep call chain then returns past the stack depth
    for (int k = 0; k < 9; k++)  step((k % 2) ? 5 : 4, 1'b0);
    for (int k = 0; k < 11; k++) step((k % 2) ? 7 : 6, 1'b0);
    // Call+ret together, then returns on an emptied stack
    repeat (4) step(10, 1'b0);
    repeat (12) step(6, 1'b0);
    // Aliasing non-branch behind a trained branch
    for (int k = 0; k < 30; k++) step((k % 3 == 2) ? 2 : 1, 1'b0);
    random_run(3000);
    apply_reset(1'b1);
    repeat (6) step(0, 1'b0);
    random_run(1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
